// File: rtl/sm4_chain_seq_if.sv
// 128-bit valid/ready block stream used for the input and output sides of sm4_chain_seq.
// The master drives valid/data and the slave answers with ready.
interface sm4_chain_seq_if;
    logic         valid;
    logic         ready;
    logic [127:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sm4_chain_seq.sv
// ECB/CBC chaining sequencer wrapped around an external SM4 block core; one block in flight at a time.
// Optional core-done timeout is compiled in when the macro SM4_CHAIN_TMO_EN is defined.
module sm4_chain_seq #(
    parameter int CNT_W   = 32,
    parameter int TMO_CYC = 64
) (
    input  logic             io_mainClk,
    input  logic             resetCtrl_systemReset,
    input  logic             i_mode,
    input  logic             i_encrypt,
    input  logic [127:0]     i_iv,
    input  logic             i_iv_load,
    sm4_chain_seq_if.slave   s,
    output logic             core_start,
    output logic [127:0]     core_data,
    output logic             core_encrypt,
    input  logic             core_done,
    input  logic [127:0]     core_result,
    sm4_chain_seq_if.master  m,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_block_cnt,
    output logic             o_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [127:0]       chain;
    logic [127:0]       blk;
    logic [127:0]       core_data_r;
    logic [127:0]       m_data_r;
    logic               mode_r;
    logic               enc_r;
    logic [CNT_W-1:0]   cnt;
    logic               s_ready_c;
    logic               m_valid_c;
    logic               accept;
    logic               capture;
    logic               deliver;
    logic               iv_write;
    logic               tmo_hit;

    assign iv_write = (state == IDLE) && i_iv_load;
    assign accept   = s.valid && s_ready_c;
    assign capture  = (state == WAIT) && core_done;
    assign deliver  = m_valid_c && m.ready;

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        s_ready_c  = 1'b0;
        m_valid_c  = 1'b0;
        core_start = 1'b0;
        o_busy     = 1'b1;
        case (state)
            IDLE: begin
                o_busy    = 1'b0;
                s_ready_c = !i_iv_load;
                if (s.valid && !i_iv_load) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A result arriving in the last timeout cycle still wins.
                if (core_done) begin
                    state_nxt = OUT;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                m_valid_c = 1'b1;
                if (m.ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Mode and direction are frozen at accept so mid-block input changes cannot disturb the chain.
    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            chain       <= '0;
            blk         <= '0;
            core_data_r <= '0;
            m_data_r    <= '0;
            mode_r      <= 1'b0;
            enc_r       <= 1'b0;
            cnt         <= '0;
        end else begin
            if (iv_write) begin
                chain <= i_iv;
            end
            if (accept) begin
                blk         <= s.data;
                mode_r      <= i_mode;
                enc_r       <= i_encrypt;
                core_data_r <= (i_mode && i_encrypt) ? (s.data ^ chain) : s.data;
            end
            if (capture) begin
                m_data_r <= (mode_r && !enc_r) ? (core_result ^ chain) : core_result;
                if (mode_r) begin
                    chain <= enc_r ? core_result : blk;
                end
            end
            if (deliver) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef SM4_CHAIN_TMO_EN
    localparam int TMO_W    = $clog2(TMO_CYC + 1);
    localparam int TMO_LAST = (TMO_CYC > 1) ? (TMO_CYC - 2) : 0;

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_r;

    // Counting starts on the first WAIT cycle, so the abort edge lands TMO_CYC edges after core_start.
    assign tmo_hit = (state == WAIT) && !core_done && (tmo_cnt == TMO_W'(TMO_LAST));

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            tmo_cnt <= '0;
            err_r   <= 1'b0;
        end else begin
            if (state != WAIT) begin
                tmo_cnt <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) begin
                err_r <= 1'b1;
            end else if (iv_write) begin
                err_r <= 1'b0;
            end
        end
    end

    assign o_err = err_r;
`else
    assign tmo_hit = 1'b0;
    assign o_err   = 1'b0;
`endif

    assign s.ready      = s_ready_c;
    assign m.valid      = m_valid_c;
    assign m.data       = m_data_r;
    assign core_data    = core_data_r;
    assign core_encrypt = enc_r;
    assign o_block_cnt  = cnt;

endmodule

// File: tb/tb_sm4_chain_seq.sv
// Randomized scoreboard bench for sm4_chain_seq with a behavioural SM4 core and CBC reference model.
// Timeout checks are included when SM4_CHAIN_TMO_EN is defined.
module tb_sm4_chain_seq;

    localparam int CNT_W = 4;
    localparam int TMO   = 64;
    localparam logic [127:0] KEY     = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [2047:0] SBOX_P = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_mode = 1'b0;
    logic             i_encrypt = 1'b0;
    logic [127:0]     i_iv = '0;
    logic             i_iv_load = 1'b0;
    logic             core_start;
    logic [127:0]     core_data;
    logic             core_encrypt;
    logic             core_done = 1'b0;
    logic [127:0]     core_result = '0;
    logic             o_busy;
    logic [CNT_W-1:0] o_block_cnt;
    logic             o_err;

    sm4_chain_seq_if s_bus ();
    sm4_chain_seq_if m_bus ();

    sm4_chain_seq #(.CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
        .io_mainClk(clk), .resetCtrl_systemReset(rst),
        .i_mode(i_mode), .i_encrypt(i_encrypt), .i_iv(i_iv), .i_iv_load(i_iv_load),
        .s(s_bus),
        .core_start(core_start), .core_data(core_data), .core_encrypt(core_encrypt),
        .core_done(core_done), .core_result(core_result),
        .m(m_bus),
        .o_busy(o_busy), .o_block_cnt(o_block_cnt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad = 0;
    logic [127:0]     sb_q[$];
    logic [127:0]     out_log[$];
    logic [127:0]     tb_chain = '0;
    logic [CNT_W-1:0] exp_cnt = '0;
    bit               hold_ready = 1'b0;
    int               core_lat = 0;
    bit               core_mute = 1'b0;
    bit               core_pend = 1'b0;
    logic             prev_start = 1'b0;

    // ---------------- SM4 reference ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [2047:0] t;
        logic [31:0]   r;
        t = SBOX_P;
        for (int j = 0; j < 4; j++) begin
            int idx;
            idx = int'(a[8*j +: 8]);
            r[8*j +: 8] = t[2047 - 8*idx -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] sm4(input logic [127:0] blk, input logic enc);
        logic [31:0]  k[36];
        logic [31:0]  rk[32];
        logic [31:0]  x[36];
        logic [31:0]  fk[4];
        logic [31:0]  ck;
        logic [31:0]  t;
        logic [127:0] mk;
        mk = KEY;
        fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
        for (int i = 0; i < 4; i++) begin
            k[i] = mk[127 - 32*i -: 32] ^ fk[i];
            x[i] = blk[127 - 32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i) * 7), 8'((4*i + 1) * 7), 8'((4*i + 2) * 7), 8'((4*i + 3) * 7)};
            t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk[i] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            k[i+4] = rk[i];
        end
        for (int i = 0; i < 32; i++) begin
            t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (enc ? rk[i] : rk[31-i]));
            x[i+4] = x[i] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- check helpers ----------------
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [127:0] blk, input logic mode, input logic enc, input bit push);
        int           n;
        logic [127:0] r;
        n = 0;
        @(negedge clk);
        s_bus.valid = 1'b1;
        s_bus.data  = blk;
        i_mode      = mode;
        i_encrypt   = enc;
        while (!s_bus.ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_bus.ready) begin
            flagFail("s_ready_timeout");
            s_bus.valid = 1'b0;
            return;
        end
        if (push) begin
            if (!mode) begin
                r = sm4(blk, enc);
            end else if (enc) begin
                r = sm4(blk ^ tb_chain, 1'b1);
                tb_chain = r;
            end else begin
                r = sm4(blk, 1'b0) ^ tb_chain;
                tb_chain = blk;
            end
            sb_q.push_back(r);
        end
        @(negedge clk);
        s_bus.valid = 1'b0;
        s_bus.data  = rand128();
        i_mode      = 1'($urandom_range(0, 1));
        i_encrypt   = 1'($urandom_range(0, 1));
    endtask

    task automatic loadIv(input logic [127:0] iv);
        int n;
        n = 0;
        @(negedge clk);
        while (o_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        i_iv      = iv;
        i_iv_load = 1'b1;
        #1;
        checkOutput("iv_load_blocks_s_ready", 128'(s_bus.ready), 128'(0));
        @(negedge clk);
        i_iv_load = 1'b0;
        tb_chain  = iv;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || o_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || o_busy) flagFail("drain_timeout");
    endtask

    task automatic doReset();
        @(negedge clk);
        rst         = 1'b1;
        s_bus.valid = 1'b0;
        i_iv_load   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 128'(o_busy), 128'(0));
        checkOutput("rst_s_ready", 128'(s_bus.ready), 128'(1));
        checkOutput("rst_m_valid", 128'(m_bus.valid), 128'(0));
        checkOutput("rst_core_start", 128'(core_start), 128'(0));
        checkOutput("rst_core_data", core_data, 128'(0));
        checkOutput("rst_m_data", m_bus.data, 128'(0));
        checkOutput("rst_block_cnt", 128'(o_block_cnt), 128'(0));
        checkOutput("rst_err", 128'(o_err), 128'(0));
        rst = 1'b0;
        sb_q.delete();
        tb_chain = '0;
        exp_cnt  = '0;
    endtask

    // ---------------- behavioural SM4 core ----------------
    initial begin
        logic [127:0] d;
        logic         e;
        int           lat;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!rst && core_start) begin
                d = core_data;
                e = core_encrypt;
                core_pend = 1'b1;
                lat = (core_lat > 0) ? core_lat : int'($urandom_range(1, 8));
                repeat (lat) @(negedge clk);
                if (!core_mute) begin
                    core_result = sm4(d, e);
                    core_done   = 1'b1;
                end
                core_pend = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (core_start && prev_start) flagFail("core_start_two_cycles");
            prev_start = core_start;
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    initial begin
        logic [127:0] exp;
        m_bus.ready = 1'b0;
        forever begin
            @(negedge clk);
            m_bus.ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (!rst && m_bus.valid) begin
                if (sb_q.size() == 0) begin
                    flagFail("unexpected_m_valid");
                end else if (m_bus.ready) begin
                    exp = sb_q.pop_front();
                    checkOutput("m_data", m_bus.data, exp);
                    checkOutput("block_cnt", 128'(o_block_cnt), 128'(exp_cnt));
                    exp_cnt++;
                    out_log.push_back(m_bus.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] pt;
        logic [127:0] c1;
        logic [127:0] c2;
        logic [127:0] hold_exp;
        int           n;
        s_bus.valid = 1'b0;
        s_bus.data  = '0;
        pt = KEY;
        doReset();

        out_log.delete();
        applyStimulus(pt, 1'b0, 1'b1, 1'b1);
        waitDrain();
        if (out_log.size() < 1) flagFail("ecb_kat_missing");
        else checkOutput("ecb_kat", out_log[0], KAT_CT);
        checkOutput("ecb_cnt_one", 128'(o_block_cnt), 128'(1));

        out_log.delete();
        applyStimulus(KAT_CT, 1'b0, 1'b0, 1'b1);
        waitDrain();
        if (out_log.size() < 1) flagFail("ecb_dec_missing");
        else checkOutput("ecb_dec", out_log[0], pt);

        loadIv('0);
        out_log.delete();
        applyStimulus(pt, 1'b1, 1'b1, 1'b1);
        applyStimulus(pt, 1'b1, 1'b1, 1'b1);
        waitDrain();
        c1 = KAT_CT;
        c2 = '0;
        if (out_log.size() < 2) begin
            flagFail("cbc_enc_missing");
        end else begin
            c1 = out_log[0];
            c2 = out_log[1];
            checkOutput("cbc_c1", c1, KAT_CT);
            total++;
            if (c2 === c1) begin
                bad++;
                $display("[TB] FAIL cbc_c2_differs: got %h expected not %h", c2, c1);
            end
        end

        loadIv('0);
        out_log.delete();
        applyStimulus(c1, 1'b1, 1'b0, 1'b1);
        applyStimulus(c2, 1'b1, 1'b0, 1'b1);
        applyStimulus(c2, 1'b1, 1'b0, 1'b1);
        waitDrain();
        if (out_log.size() < 2) begin
            flagFail("cbc_dec_missing");
        end else begin
            checkOutput("cbc_p1", out_log[0], pt);
            checkOutput("cbc_p2", out_log[1], pt);
        end

        hold_ready = 1'b1;
        applyStimulus(rand128(), 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!m_bus.valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_bus.valid || sb_q.size() == 0) begin
            flagFail("hold_no_m_valid");
        end else begin
            hold_exp = sb_q[0];
            repeat (10) begin
                checkOutput("hold_m_data", m_bus.data, hold_exp);
                checkOutput("hold_m_valid", 128'(m_bus.valid), 128'(1));
                checkOutput("hold_s_ready", 128'(s_bus.ready), 128'(0));
                checkOutput("hold_cnt", 128'(o_block_cnt), 128'(exp_cnt));
                @(negedge clk);
            end
        end
        hold_ready = 1'b0;
        waitDrain();

        core_lat = 20;
        applyStimulus(rand128(), 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!core_pend && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        doReset();
        n = 0;
        while (core_pend && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("post_rst_m_valid", 128'(m_bus.valid), 128'(0));
        checkOutput("post_rst_cnt", 128'(o_block_cnt), 128'(0));
        core_lat = 0;
        out_log.delete();
        applyStimulus(pt, 1'b1, 1'b1, 1'b1);
        waitDrain();
        if (out_log.size() < 1) flagFail("post_rst_missing");
        else checkOutput("post_rst_chain_zero", out_log[0], KAT_CT);

        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 5) == 0) loadIv(rand128());
            applyStimulus(rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                i_iv      = rand128();
                i_iv_load = 1'b1;
                @(negedge clk);
                i_iv_load = 1'b0;
            end
        end
        waitDrain();

`ifdef SM4_CHAIN_TMO_EN
        core_mute = 1'b1;
        applyStimulus(rand128(), 1'b1, 1'b1, 1'b0);
        checkOutput("tmo_core_start", 128'(core_start), 128'(1));
        n = 0;
        while (o_busy && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo_cycles", 128'(n), 128'(TMO));
        checkOutput("tmo_err_set", 128'(o_err), 128'(1));
        while (core_pend) @(negedge clk);
        core_mute = 1'b0;
        applyStimulus(rand128(), 1'b1, 1'b1, 1'b1);
        waitDrain();
        checkOutput("tmo_err_sticky", 128'(o_err), 128'(1));
        loadIv(rand128());
        checkOutput("tmo_err_cleared", 128'(o_err), 128'(0));
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm4_chain_seq.md
SM4_CHAIN_SEQ -- requirements
Module: sm4_chain_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the processed-block counter.
REQ-002 SHALL have parameter TMO_CYC, default 64, core-done timeout in cycles; used only with SM4_CHAIN_TMO_EN.
REQ-003 Port io_mainClk  in  1: single clock; all logic rising-edge.
REQ-004 Port resetCtrl_systemReset  in  1: synchronous, active-high reset.
REQ-005 Port i_mode  in  1: 0 = ECB, 1 = CBC.
REQ-006 Port i_encrypt  in  1: 1 = encrypt, 0 = decrypt.
REQ-007 Port i_iv  in  128: initialisation vector.
REQ-008 Port i_iv_load  in  1: one-cycle load strobe for i_iv.
REQ-009 Port s_valid / s_ready / s_data  in / out / in  1/1/128: input block stream.
REQ-010 Port core_start  out  1: one-cycle start pulse to the SM4 core.
REQ-011 Port core_data  out  128: block to the core; held stable from core_start until core_done.
REQ-012 Port core_encrypt  out  1: direction to the core; held with core_data.
REQ-013 Port core_done / core_result  in / in  1/128: core completion pulse and result.
REQ-014 Port m_valid / m_ready / m_data  out / in / out  1/1/128: output block stream.
REQ-015 Port o_busy  out  1: high in every state except IDLE.
REQ-016 Port o_block_cnt  out  CNT_W: count of blocks delivered on m.
REQ-017 Port o_err  out  1: sticky core-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-019 IDLE: s_ready = 1 unless i_iv_load = 1; i_iv_load in IDLE writes the chain register from i_iv; i_iv_load in other states is ignored.
REQ-020 IDLE with s_valid & s_ready SHALL latch s_data, i_mode and i_encrypt, then go to ISSUE; mode and direction changes mid-block have no effect.
REQ-021 ISSUE SHALL assert core_start for exactly one cycle, then go to WAIT.
REQ-022 core_data: CBC encrypt = block XOR chain; all other cases = block.
REQ-023 WAIT on core_done SHALL capture the result and go to OUT; core_done outside WAIT is ignored.
REQ-024 m_data: CBC decrypt = core_result XOR chain; otherwise core_result; registered, stable while m_valid.
REQ-025 Chain update on result capture: CBC encrypt -> chain = core_result; CBC decrypt -> chain = latched input ciphertext; ECB -> unchanged.
REQ-026 OUT: m_valid = 1 until m_ready; on handshake o_block_cnt increments (wraps 2^CNT_W-1 -> 0) and the FSM returns to IDLE.
REQ-027 Throughput: minimum 4 cycles plus core latency per block; s_ready SHALL be 0 outside IDLE.

Reset
REQ-028 On reset, in any state including WAIT: FSM = IDLE; chain = 0; o_block_cnt = 0; o_err = 0; m_valid, core_start, o_busy = 0; s_ready = 1; core_data, m_data = 0.

Configuration
REQ-029 Macro SM4_CHAIN_TMO_EN defined: counter runs in WAIT; if core_done has not arrived TMO_CYC cycles after core_start, FSM -> IDLE, block dropped, chain unchanged, o_err set; o_err clears only on reset or on i_iv_load in IDLE.
REQ-030 Macro SM4_CHAIN_TMO_EN undefined: no timeout logic; WAIT waits indefinitely; o_err tied 0.

Verification
REQ-031 ECB encrypt, core model key 0123456789ABCDEFFEDCBA9876543210, block same value -> m_data 681EDF34D206965E86B3E94F536E4246, o_block_cnt = 1.
REQ-032 CBC encrypt, IV 0, two identical blocks 0123456789ABCDEFFEDCBA9876543210 -> first output 681EDF34D206965E86B3E94F536E4246; second output = SM4(block XOR first output), not equal to the first.
REQ-033 CBC decrypt of the two REQ-032 ciphertexts, same IV -> both plaintexts recovered exactly; chain equals second ciphertext afterwards.
REQ-034 m_ready held low 10 cycles in OUT -> m_data stable, s_ready = 0, count unchanged until the handshake.
REQ-035 Reset pulsed in WAIT, then core_done delivered -> no m_valid; all outputs at reset values; next block processed with chain = 0.
REQ-036 With SM4_CHAIN_TMO_EN, core never returns done -> IDLE and o_err = 1 at TMO_CYC cycles after core_start; i_iv_load clears o_err.
